// File: rtl/freq_calc.sv
// Frequency back-end: fx_hz = (CLK_FS*GATE_TIME)/fs_cnt via a sequential restoring divider.
// Optional build macro FREQ_CALC_ROUND_EN selects round-to-nearest instead of floor.
module freq_calc #(
  parameter int CLK_FS    = 100_000_000,
  parameter int GATE_TIME = 100,
  parameter int NUM_W     = 48
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [31:0] fs_cnt,
  input  logic        measurement_end_flag,
  output logic [31:0] fx_hz,
  output logic        fx_valid,
  output logic        busy,
  output logic        ovf,
  output logic        div_err
);

  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [NUM_W-1:0] NUM = NUM_W'(CLK_FS) * NUM_W'(GATE_TIME);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        divisor_reg;
  logic [NUM_W-1:0]   dividend_reg;
  logic [NUM_W-1:0]   quot_reg;
  logic [31:0]        rem_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               err_pend_reg;

  logic [32:0]        rem_shift;
  logic               rem_ge;
  logic [NUM_W-1:0]   load_dividend;

  // Remainder stays below the 32-bit divisor, so the trial value needs only 33 bits.
  assign rem_shift = {rem_reg, dividend_reg[NUM_W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor_reg});

`ifdef FREQ_CALC_ROUND_EN
  assign load_dividend = NUM + NUM_W'(divisor_reg >> 1);
`else
  assign load_dividend = NUM;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (measurement_end_flag) state_next = LOAD;
      LOAD: state_next = (divisor_reg == 32'd0) ? DONE : DIV;
      DIV:  if (cnt_reg == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor_reg  <= '0;
      dividend_reg <= '0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      err_pend_reg <= 1'b0;
      fx_hz        <= '0;
      fx_valid     <= 1'b0;
      ovf          <= 1'b0;
      div_err      <= 1'b0;
    end else begin
      fx_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (measurement_end_flag) divisor_reg <= fs_cnt;
        end
        LOAD: begin
          if (divisor_reg == 32'd0) begin
            quot_reg     <= '0;
            err_pend_reg <= 1'b1;
          end else begin
            dividend_reg <= load_dividend;
            rem_reg      <= '0;
            cnt_reg      <= CNT_W'(NUM_W - 1);
            err_pend_reg <= 1'b0;
          end
        end
        DIV: begin
          // Dividend is shifted out MSB first; quotient bits shift in from the LSB.
          dividend_reg <= {dividend_reg[NUM_W-2:0], 1'b0};
          quot_reg     <= {quot_reg[NUM_W-2:0], rem_ge};
          rem_reg      <= rem_ge ? 32'(rem_shift - {1'b0, divisor_reg}) : rem_shift[31:0];
          cnt_reg      <= cnt_reg - 1'b1;
        end
        DONE: begin
          fx_valid <= 1'b1;
          div_err  <= err_pend_reg;
          if (quot_reg[NUM_W-1:32] != '0) begin
            fx_hz <= 32'hFFFF_FFFF;
            ovf   <= 1'b1;
          end else begin
            fx_hz <= quot_reg[31:0];
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_calc.sv
// Scoreboard bench for freq_calc: expected results queued at flag acceptance, checked on fx_valid.
module tb_freq_calc;
  localparam int CLK_FS    = 100_000_000;
  localparam int GATE_TIME = 100;
  localparam int NUM_W     = 48;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [31:0] fs_cnt;
  logic        measurement_end_flag;
  logic [31:0] fx_hz;
  logic        fx_valid;
  logic        busy;
  logic        ovf;
  logic        div_err;

  freq_calc #(.CLK_FS(CLK_FS), .GATE_TIME(GATE_TIME), .NUM_W(NUM_W)) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .fs_cnt(fs_cnt),
    .measurement_end_flag(measurement_end_flag),
    .fx_hz(fx_hz),
    .fx_valid(fx_valid),
    .busy(busy),
    .ovf(ovf),
    .div_err(div_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] hz;
    logic        ovf;
    logic        err;
    int          due;
    int          fs;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          valid_cnt = 0;
  int          push_cnt = 0;
  logic [31:0] last_hz = 32'd0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    chk_cnt++;
    if (obs === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  function automatic exp_t model(input int fs);
    exp_t e;
    longint unsigned num, q;
    num = longint'(CLK_FS) * longint'(GATE_TIME);
    e.fs = fs;
    e.due = 0;
    if (fs == 0) begin
      e.hz = 32'd0; e.ovf = 1'b0; e.err = 1'b1;
    end else begin
`ifdef FREQ_CALC_ROUND_EN
      q = (num + longint'(fs / 2)) / longint'(fs);
`else
      q = num / longint'(fs);
`endif
      e.err = 1'b0;
      if (q > 64'hFFFF_FFFF) begin
        e.hz = 32'hFFFF_FFFF; e.ovf = 1'b1;
      end else begin
        e.hz = q[31:0]; e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  // Monitor: every fx_valid pulse must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    if (fx_valid) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        check_value("spurious_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("result fs_cnt=%0d fx_hz=%0d ovf=%0d div_err=%0d cycle=%0d", e.fs, fx_hz, ovf, div_err, cyc);
        check_value("fx_hz", fx_hz, e.hz);
        check_value("ovf", ovf, e.ovf);
        check_value("div_err", div_err, e.err);
        check_value("latency", cyc, e.due);
        last_hz = e.hz;
      end
    end
  end

  task automatic send_flag(input int fs, input bit accept);
    exp_t e;
    @(negedge sys_clk);
    fs_cnt = fs;
    measurement_end_flag = 1'b1;
    if (!accept) check_value("busy_at_ignored_flag", busy, 1);
    @(posedge sys_clk);
    #1;
    measurement_end_flag = 1'b0;
    if (accept) begin
      e = model(fs);
      e.due = cyc + ((fs == 0) ? 2 : NUM_W + 2);
      sb_q.push_back(e);
      push_cnt++;
      check_value("busy_rise", busy, 1);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge sys_clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_value("timeout_pending", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge sys_clk);
    check_value("valid_one_cycle", fx_valid, 0);
    check_value("busy_after", busy, 0);
    check_value("fx_hz_hold", fx_hz, last_hz);
  endtask

  initial begin
    rst_n = 1'b0;
    fs_cnt = 32'd0;
    measurement_end_flag = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_value("rst_fx_hz", fx_hz, 0);
    check_value("rst_fx_valid", fx_valid, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_ovf", ovf, 0);
    check_value("rst_div_err", div_err, 0);
    rst_n = 1'b1;

    send_flag(10_000, 1'b1); wait_done();
    send_flag(6, 1'b1);      wait_done();
    send_flag(2, 1'b1);      wait_done();
    send_flag(3, 1'b1);      wait_done();
    send_flag(0, 1'b1);      wait_done();

    // Second flag while busy must be dropped.
    send_flag(10_000, 1'b1);
    repeat (9) @(posedge sys_clk);
    send_flag(20_000, 1'b0);
    wait_done();
    repeat (60) @(posedge sys_clk);

    // Reset in the middle of a division aborts it with no result.
    send_flag(10_000, 1'b1);
    repeat (19) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b0;
    sb_q.delete();
    push_cnt--;
    #1;
    check_value("abort_fx_hz", fx_hz, 0);
    check_value("abort_busy", busy, 0);
    check_value("abort_ovf", ovf, 0);
    check_value("abort_div_err", div_err, 0);
    check_value("abort_fx_valid", fx_valid, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (60) @(posedge sys_clk);
    last_hz = 32'd0;
    send_flag(10_000, 1'b1); wait_done();

    check_value("valid_count", valid_cnt, push_cnt);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
